// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register link: frame layout, register map,
// controller state encoding and a small elaboration helper.
package spi_pkg;

    localparam int FRAME_BITS = 16;
    localparam int RW_BIT     = 15;
    localparam int ADDR_MSB   = 14;
    localparam int ADDR_LSB   = 8;

    localparam logic [6:0] REG_OUT_7_0  = 7'h00;
    localparam logic [6:0] REG_OUT_15_8 = 7'h01;
    localparam logic [6:0] REG_PWM_7_0  = 7'h02;
    localparam logic [6:0] REG_PWM_15_8 = 7'h03;
    localparam logic [6:0] REG_PWM_DUTY = 7'h04;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } spi_state_e;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/spi_controller_if.sv
// System-side request/response bundle of the SPI controller.
interface spi_controller_if;
    import spi_pkg::*;

    // Handshake: a request transfers on a clock edge where req_valid && req_ready;
    // the requester holds req_* stable while req_valid is high and ready is low.
    logic                         req_valid;
    logic                         req_ready;
    logic                         req_write;
    logic [ADDR_MSB-ADDR_LSB:0]   req_addr;
    logic [7:0]                   req_data;
    logic                         busy;
    logic                         done;
    logic [7:0]                   rd_data;

    modport master (
        output req_valid, req_write, req_addr, req_data,
        input  req_ready, busy, done, rd_data
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_data,
        output req_ready, busy, done, rd_data
    );

endinterface

// File: rtl/spi_sclk_gen.sv
// SCLK divider: while enabled, SCLK is low for CLK_DIV cycles then high for
// CLK_DIV cycles; fall/sample strobe the last cycle of each high phase.
module spi_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic sclk,
    output logic fall,
    output logic sample
);

    localparam int              CW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0]   RELOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sclk_q, sclk_d;
    logic          phase_end;

    always_comb begin
        phase_end = en && (cnt_q == '0);
        cnt_d     = RELOAD;
        sclk_d    = 1'b0;
        if (en) begin
            if (cnt_q == '0) begin
                cnt_d  = RELOAD;
                sclk_d = ~sclk_q;
            end else begin
                cnt_d  = cnt_q - 1'b1;
                sclk_d = sclk_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= RELOAD;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk   = sclk_q;
    assign fall   = phase_end && sclk_q;
    assign sample = phase_end && sclk_q;

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 initiator: turns one request into a 16-bit {rw, addr, data} frame
// and returns the last 8 CIPO bits of read frames on rd_data.
module spi_controller
    import spi_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4,
    parameter int CS_IDLE  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    spi_controller_if.slave  req,
    output logic             nCS,
    output logic             SCLK,
    output logic             COPI,
    input  logic             CIPO,
    output logic [2:0]       dbg_state
);

    localparam int PH_MAX = max4(CLK_DIV, CS_SETUP, CS_HOLD, CS_IDLE);
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam logic [PH_W-1:0] SETUP_LD = PH_W'(CS_SETUP - 1);
    localparam logic [PH_W-1:0] HOLD_LD  = PH_W'(CS_HOLD - 1);
    localparam logic [PH_W-1:0] IDLE_LD  = PH_W'(CS_IDLE - 1);

    if (CLK_DIV < 4) begin : g_bad_div
        $error("spi_controller: CLK_DIV must be >= 4");
    end
    if (CS_SETUP < 1 || CS_HOLD < 1 || CS_IDLE < 1) begin : g_bad_cs
        $error("spi_controller: CS_SETUP, CS_HOLD and CS_IDLE must be >= 1");
    end

    spi_state_e            state_q, state_d;
    logic [PH_W-1:0]       phase_q, phase_d;
    logic [3:0]            bit_q, bit_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic                  is_read_q, is_read_d;
    logic                  ncs_q, ncs_d;
    logic                  copi_q, copi_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [7:0]            rd_data_q, rd_data_d;
    logic                  cipo_meta_q, cipo_sync_q;
    logic                  sclk_w, fall_w, sample_w;

    spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (state_q == ST_SHIFT),
        .sclk   (sclk_w),
        .fall   (fall_w),
        .sample (sample_w)
    );

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        is_read_d = is_read_q;
        ncs_d     = ncs_q;
        copi_d    = copi_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rd_data_d = rd_data_q;
        case (state_q)
            ST_IDLE: begin
                if (req.req_valid) begin
                    state_d   = ST_SETUP;
                    shift_d   = {req.req_write, req.req_addr,
                                 req.req_write ? req.req_data : 8'h00};
                    is_read_d = ~req.req_write;
                    ncs_d     = 1'b0;
                    copi_d    = req.req_write;
                    phase_d   = SETUP_LD;
                    busy_d    = 1'b1;
                end
            end
            ST_SETUP: begin
                if (phase_q == '0) begin
                    state_d = ST_SHIFT;
                    bit_d   = 4'd15;
                end else begin
                    phase_d = phase_q - 1'b1;
                end
            end
            ST_SHIFT: begin
                // Received bits enter at the LSB as frame bits leave at the MSB,
                // so after bit 0 the low byte holds the CIPO bits of frame bits 7:0.
                if (sample_w) begin
                    shift_d = {shift_q[FRAME_BITS-2:0], cipo_sync_q};
                end
                if (fall_w) begin
                    if (bit_q == 4'd0) begin
                        state_d = ST_HOLD;
                        phase_d = HOLD_LD;
                    end else begin
                        bit_d  = bit_q - 4'd1;
                        copi_d = shift_q[FRAME_BITS-2];
                    end
                end
            end
            ST_HOLD: begin
                if (phase_q == '0) begin
                    state_d = ST_GAP;
                    ncs_d   = 1'b1;
                    copi_d  = 1'b0;
                    phase_d = IDLE_LD;
                end else begin
                    phase_d = phase_q - 1'b1;
                end
            end
            ST_GAP: begin
                if (phase_q == '0) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    if (is_read_q) rd_data_d = shift_q[7:0];
                end else begin
                    phase_d = phase_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            phase_q     <= '0;
            bit_q       <= 4'd0;
            shift_q     <= '0;
            is_read_q   <= 1'b0;
            ncs_q       <= 1'b1;
            copi_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_data_q   <= 8'h00;
            cipo_meta_q <= 1'b0;
            cipo_sync_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            is_read_q   <= is_read_d;
            ncs_q       <= ncs_d;
            copi_q      <= copi_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_data_q   <= rd_data_d;
            cipo_meta_q <= CIPO;
            cipo_sync_q <= cipo_meta_q;
        end
    end

    assign req.req_ready = (state_q == ST_IDLE);
    assign req.busy      = busy_q;
    assign req.done      = done_q;
    assign req.rd_data   = rd_data_q;
    assign nCS           = ncs_q;
    assign SCLK          = sclk_w;
    assign COPI          = copi_q;
    assign dbg_state     = state_q;

endmodule
